// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC arbiter slice.
package cordic_pkg;

    localparam int CORDIC_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } cordic_arb_state_t;

endpackage

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker: grants the first set request bit at or
// after ptr, wrapping around N_REQ.
module cordic_rr_pick #(
    parameter int N_REQ = 2,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_id,
    output logic             any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk offsets 0..N_REQ-1 from ptr (modulo N_REQ) and keep the first hit.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one rotational CORDIC between N_REQ requesters,
// with a watchdog that aborts transactions the CORDIC never completes.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int WIDTH   = CORDIC_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_x,
    input  logic [N_REQ*WIDTH-1:0]     req_y,
    input  logic [N_REQ*WIDTH-1:0]     req_theta,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_x,
    output logic [WIDTH-1:0]           rsp_y,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [WIDTH-1:0]           cordic_x,
    output logic [WIDTH-1:0]           cordic_y,
    output logic [WIDTH-1:0]           cordic_theta,
    output logic                       cordic_start,
    input  logic [WIDTH-1:0]           cordic_xprime,
    input  logic [WIDTH-1:0]           cordic_yprime,
    input  logic                       cordic_done
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    cordic_arb_state_t state;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     win_id;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  op_x, op_y, op_theta;
    logic [WIDTH-1:0]  res_x, res_y;

    logic [N_REQ-1:0]  grant;
    logic [IW-1:0]     grant_id;
    logic              any;

    logic [WIDTH-1:0]  x_arr [N_REQ];
    logic [WIDTH-1:0]  y_arr [N_REQ];
    logic [WIDTH-1:0]  t_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign x_arr[g] = req_x[g*WIDTH +: WIDTH];
        assign y_arr[g] = req_y[g*WIDTH +: WIDTH];
        assign t_arr[g] = req_theta[g*WIDTH +: WIDTH];
    end

    cordic_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    // Accept is combinational so the winner sees ready in its request cycle;
    // held low during reset so every output is quiet while reset is asserted.
    assign req_ready = (state == IDLE && !reset) ? grant : '0;

    assign cordic_x     = op_x;
    assign cordic_y     = op_y;
    assign cordic_theta = op_theta;
    assign rsp_x        = res_x;
    assign rsp_y        = res_y;
    assign rsp_id       = win_id;

    // Arbitration FSM with registered CORDIC/response strobes and watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            win_id       <= '0;
            cnt          <= '0;
            op_x         <= '0;
            op_y         <= '0;
            op_theta     <= '0;
            res_x        <= '0;
            res_y        <= '0;
            cordic_start <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        op_x         <= x_arr[grant_id];
                        op_y         <= y_arr[grant_id];
                        op_theta     <= t_arr[grant_id];
                        win_id       <= grant_id;
                        cordic_start <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    cordic_start <= 1'b0;
                    cnt          <= '0;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (cordic_done) begin
                        res_x     <= cordic_xprime;
                        res_y     <= cordic_yprime;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        res_x     <= '0;
                        res_y     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    rr_ptr    <= (win_id == IW'(N_REQ - 1)) ? '0 : win_id + IW'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter with a behavioural CORDIC model.
module tb_cordic_arbiter;

    localparam int N  = 3;
    localparam int W  = 16;
    localparam int TO = 64;

    logic           clk, reset;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_x, req_y, req_theta;
    logic           rsp_valid, rsp_err, busy;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_x, rsp_y;
    logic [W-1:0]   cordic_x, cordic_y, cordic_theta;
    logic           cordic_start, cordic_done;
    logic [W-1:0]   cordic_xprime, cordic_yprime;

    cordic_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_theta(req_theta),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .rsp_err(rsp_err), .busy(busy),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_theta(cordic_theta),
        .cordic_start(cordic_start),
        .cordic_xprime(cordic_xprime), .cordic_yprime(cordic_yprime),
        .cordic_done(cordic_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // CORDIC model controls
    int         cyc = 0;
    int         due = -1;
    int         lat = 16;
    bit         never_done = 0;
    bit         use_fixed = 1;
    logic [W-1:0] fix_x = '0, fix_y = '0, mx = '0, my = '0;
    int         spur_q[$];

    // Monitor logs
    int           rsp_count = 0;
    int           last_rsp_cyc = 0;
    logic [1:0]   last_id;
    logic [W-1:0] last_x, last_y;
    logic         last_err;
    int           g_cyc[$], g_id[$], d_cyc[$];

    function automatic logic [W-1:0] ref_fx(logic [W-1:0] x, logic [W-1:0] th);
        return (x ^ 16'h5a5a) + th;
    endfunction

    function automatic logic [W-1:0] ref_fy(logic [W-1:0] y, logic [W-1:0] th);
        return y - th;
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Reference arbitration rule: first requester at or after ptr, wrapping.
    function automatic logic [N-1:0] ref_pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return onehot((p + k) % N);
        end
        return '0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] th);
        req_x[i*W +: W]     = x;
        req_y[i*W +: W]     = y;
        req_theta[i*W +: W] = th;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        spur_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Behavioural CORDIC: done exactly lat cycles after the cycle start is seen.
    initial begin
        cordic_done   = 1'b0;
        cordic_xprime = '0;
        cordic_yprime = '0;
        forever begin
            bit hit;
            @(posedge clk);
            cyc++;
            #1;
            hit = 0;
            foreach (spur_q[i]) if (spur_q[i] == cyc) hit = 1;
            if (cyc == due && !never_done) begin
                cordic_done   = 1'b1;
                cordic_xprime = mx;
                cordic_yprime = my;
            end else begin
                cordic_done   = hit;
                cordic_xprime = W'($urandom);
                cordic_yprime = W'($urandom);
            end
            @(negedge clk);
            if (reset) begin
                due = -1;
            end else if (cordic_start) begin
                due = cyc + lat;
                mx  = use_fixed ? fix_x : ref_fx(cordic_x, cordic_theta);
                my  = use_fixed ? fix_y : ref_fy(cordic_y, cordic_theta);
            end
        end
    end

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        if (req_ready != '0) begin
            g_cyc.push_back(cyc);
            g_id.push_back(oh_idx(req_ready));
        end
        if (cordic_done) d_cyc.push_back(cyc);
        if (rsp_valid) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            last_id  = rsp_id;
            last_x   = rsp_x;
            last_y   = rsp_y;
            last_err = rsp_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] mask;
        logic [W-1:0] x, y, th;
        logic [W-1:0] fx, fy;
        bit           never;
        int           exp_id;
        int           exp_lat;
        bit           exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int T, T2, c0, n, gcyc, eid, drop, ref_ptr;
        bit outst, exp_rv;
        logic [N-1:0] exp_rdy;
        logic [W-1:0] ex, ey, ew;
        logic [W-1:0] ox[N], oy[N], ot[N];

        vecs[0] = '{mask:3'b001, x:16'd0,    y:16'd1,    th:16'd20,   fx:16'd7,    fy:16'd9,    never:0, exp_id:0, exp_lat:18,   exp_err:0};
        vecs[1] = '{mask:3'b100, x:16'h0111, y:16'h0222, th:16'h0033, fx:16'h1234, fy:16'h5678, never:0, exp_id:2, exp_lat:18,   exp_err:0};
        vecs[2] = '{mask:3'b001, x:16'h0aaa, y:16'h0bbb, th:16'h0ccc, fx:16'h0f0f, fy:16'hf0f0, never:0, exp_id:0, exp_lat:18,   exp_err:0};
        vecs[3] = '{mask:3'b100, x:16'h0123, y:16'h0456, th:16'h0789, fx:16'h7fff, fy:16'h8000, never:0, exp_id:2, exp_lat:18,   exp_err:0};
        vecs[4] = '{mask:3'b111, x:16'h0010, y:16'h0020, th:16'h0030, fx:16'h0001, fy:16'hffff, never:0, exp_id:0, exp_lat:18,   exp_err:0};
        vecs[5] = '{mask:3'b111, x:16'h0040, y:16'h0050, th:16'h0060, fx:16'h2222, fy:16'h3333, never:0, exp_id:1, exp_lat:18,   exp_err:0};
        vecs[6] = '{mask:3'b010, x:16'h0070, y:16'h0080, th:16'h0090, fx:16'hbeef, fy:16'hcafe, never:1, exp_id:1, exp_lat:TO+2, exp_err:1};
        vecs[7] = '{mask:3'b011, x:16'h00a0, y:16'h00b0, th:16'h00c0, fx:16'h4444, fy:16'h5555, never:0, exp_id:0, exp_lat:18,   exp_err:0};

        reset     = 1'b1;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        req_theta = '0;
        tick();
        tick();
        #1;
        check("reset_ctl",  {req_ready, cordic_start, busy, rsp_valid, rsp_id, rsp_err}, '0);
        check("reset_data", {rsp_x, rsp_y, cordic_x}, '0);
        check("reset_ops",  {cordic_y, cordic_theta}, '0);
        tick();
        reset     = 1'b0;
        req_valid = '0;

        // Table-driven single transactions (includes wrap and timeout cases).
        foreach (vecs[v]) begin
            c0         = rsp_count;
            lat        = 16;
            use_fixed  = 1;
            never_done = vecs[v].never;
            fix_x      = vecs[v].fx;
            fix_y      = vecs[v].fy;
            for (int i = 0; i < N; i++)
                set_ops(i, W'(vecs[v].x + i * 'h1000), W'(vecs[v].y + i * 'h0100), W'(vecs[v].th + i * 'h0010));
            req_valid = vecs[v].mask;
            T = cyc;
            #1;
            check("vec_ready", req_ready, onehot(vecs[v].exp_id));
            tick();
            req_valid = '0;
            #1;
            check("vec_start", {cordic_start, busy}, 2'b11);
            check("vec_ops", {cordic_x, cordic_y, cordic_theta},
                  {W'(vecs[v].x + vecs[v].exp_id * 'h1000), W'(vecs[v].y + vecs[v].exp_id * 'h0100),
                   W'(vecs[v].th + vecs[v].exp_id * 'h0010)});
            n = 0;
            while (rsp_count == c0 && n < TO + 40) begin
                tick();
                n++;
            end
            check("vec_rsp_count", rsp_count - c0, 1);
            check("vec_rsp_lat", last_rsp_cyc - T, vecs[v].exp_lat);
            ex = vecs[v].exp_err ? '0 : vecs[v].fx;
            ey = vecs[v].exp_err ? '0 : vecs[v].fy;
            check("vec_rsp_data", {last_id, last_err, last_x, last_y}, {2'(vecs[v].exp_id), vecs[v].exp_err, ex, ey});
        end
        never_done = 0;

        // Contention: requesters 0 and 1 held high together.
        apply_reset();
        lat       = 4;
        use_fixed = 0;
        for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom), W'($urandom));
        g_cyc.delete();
        g_id.delete();
        d_cyc.delete();
        req_valid = 3'b011;
        n = 0;
        while (g_id.size() < 4 && n < 200) begin
            tick();
            n++;
        end
        req_valid = '0;
        repeat (12) tick();
        check("cont_grants", g_id.size(), 4);
        if (g_id.size() >= 4 && d_cyc.size() >= 3) begin
            for (int k = 0; k < 4; k++) check("cont_id", g_id[k], k % 2);
            for (int k = 1; k < 4; k++) check("cont_gap", g_cyc[k] - d_cyc[k-1], 2);
        end

        // Spurious done in IDLE and ISSUE.
        apply_reset();
        c0 = rsp_count;
        spur_q.push_back(cyc + 1);
        repeat (3) tick();
        #1;
        check("spur_idle", {rsp_count - c0, busy}, '0);
        tick();
        spur_q.push_back(cyc + 1);
        lat       = 16;
        use_fixed = 1;
        fix_x     = 16'h0123;
        fix_y     = 16'h0456;
        set_ops(0, 16'h1111, 16'h2222, 16'h3333);
        req_valid = 3'b001;
        T = cyc;
        tick();
        req_valid = '0;
        repeat (24) tick();
        check("spur_count", rsp_count - c0, 1);
        check("spur_lat", last_rsp_cyc - T, 18);
        check("spur_data", {last_x, last_y, last_err}, {16'h0123, 16'h0456, 1'b0});

        // Reset in the middle of WAIT.
        apply_reset();
        c0    = rsp_count;
        fix_x = 16'h0003;
        fix_y = 16'h0004;
        set_ops(0, 16'h0aa0, 16'h0bb0, 16'h0cc0);
        set_ops(1, 16'h0dd0, 16'h0ee0, 16'h0ff0);
        req_valid = 3'b001;
        T = cyc;
        tick();
        req_valid = '0;
        repeat (7) tick();
        reset     = 1'b1;
        req_valid = 3'b010;
        #1;
        check("rst_wait_ctl",  {req_ready, cordic_start, busy, rsp_valid, rsp_err, rsp_id}, '0);
        check("rst_wait_data", {rsp_x, rsp_y, cordic_x, cordic_y}, '0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_accept", req_ready, 3'b010);
        T2 = cyc;
        tick();
        req_valid = '0;
        n = 0;
        while (rsp_count == c0 && n < 60) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("rst_rsp_count", rsp_count - c0, 1);
        check("rst_rsp", {last_id, last_err, last_x, last_y}, {2'd1, 1'b0, 16'h0003, 16'h0004});
        check("rst_rsp_lat", last_rsp_cyc - T2, 18);

        // Randomized traffic against the reference arbitration/latency model.
        apply_reset();
        use_fixed = 0;
        lat       = $urandom_range(1, 6);
        outst     = 0;
        ref_ptr   = 0;
        drop      = -1;
        gcyc      = 0;
        eid       = 0;
        ex        = '0;
        ey        = '0;
        for (int c = 0; c < 1200; c++) begin
            if (drop >= 0) begin
                req_valid[drop] = 1'b0;
                drop = -1;
            end
            if (c < 1150) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                        ox[i] = W'($urandom);
                        oy[i] = W'($urandom);
                        ot[i] = W'($urandom);
                        set_ops(i, ox[i], oy[i], ot[i]);
                        req_valid[i] = 1'b1;
                    end
                end
            end
            #1;
            exp_rdy = outst ? '0 : ref_pick(req_valid, ref_ptr);
            check("rnd_ready", req_ready, exp_rdy);
            exp_rv = outst && (cyc == gcyc + 2 + lat);
            check("rnd_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                ew = '0;
                check("rnd_rsp_data", {rsp_id, rsp_err, rsp_x, rsp_y}, {2'(eid), 1'b0, ex, ey});
                outst   = 0;
                ref_ptr = (eid + 1) % N;
            end
            if (exp_rdy != '0) begin
                outst = 1;
                eid   = oh_idx(exp_rdy);
                gcyc  = cyc;
                ex    = ref_fx(ox[eid], ot[eid]);
                ey    = ref_fy(oy[eid], ot[eid]);
                drop  = eid;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
